// File: rtl/msi001_spi_slave.sv
// msi001_spi_slave: receive side of the MSI001 3-wire SPI write port.
// Oversamples SCLK/SDATA/EN on clk, shifts MSB-first words while EN is low,
// checks the frame length on EN rise and updates a 16-entry register shadow.
// Ports:
//   clk, reset            fabric clock (>= 4x SCLK), synchronous active-high reset
//   spi_sclk_in           SPI clock from master, idle low
//   spi_data_in           SPI data, sampled on SCLK rising edge
//   spi_en_in             SPI enable, active low; rising edge closes the frame
//   word_out              last correctly framed word
//   word_valid            one-cycle pulse on a good frame (word_out/shadow update)
//   frame_err             one-cycle pulse on a frame with bit count != WORD_W
//   busy                  high while shifting a frame
//   rd_addr / rd_data     combinational shadow read port
module msi001_spi_slave #(
    parameter int unsigned WORD_W      = 24,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_sclk_in,
    input  logic                     spi_data_in,
    input  logic                     spi_en_in,
    output logic [WORD_W-1:0]        word_out,
    output logic                     word_valid,
    output logic                     frame_err,
    output logic                     busy,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [WORD_W-ADDR_W-1:0] rd_data
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DATA_W = WORD_W - ADDR_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] en_sync_q;
    logic                   sclk_dly_q;
    logic                   en_dly_q;
    logic [SYNC_STAGES:0]   prime_q;

    logic sclk_s;
    logic data_s;
    logic en_s;
    logic sclk_rise;
    logic en_rise;
    logic en_fall;
    logic primed;

    state_t              state_q;
    logic [WORD_W-1:0]   shift_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORD_W-1:0]   word_q;
    logic                word_valid_q;
    logic                frame_err_q;
    logic [DATA_W-1:0]   shadow_q [DEPTH];

    // Input synchronisers plus one delayed copy for edge detection.
    // prime_q fills with ones after reset so WAIT_IDLE only trusts en_s once
    // the reset value (1) has been flushed out of the EN chain; otherwise a
    // reset taken with EN low would look like an idle bus followed by a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            data_sync_q <= '0;
            en_sync_q   <= '1;
            sclk_dly_q  <= 1'b0;
            en_dly_q    <= 1'b1;
            prime_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_in};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], spi_data_in};
            en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], spi_en_in};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            en_dly_q    <= en_sync_q[SYNC_STAGES-1];
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign en_s      = en_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign en_rise   = en_s & ~en_dly_q;
    assign en_fall   = ~en_s & en_dly_q;
    assign primed    = prime_q[SYNC_STAGES];

    // Frame FSM, shifter, bit counter, output pulses and shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                WAIT_IDLE: begin
                    if (primed && en_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (en_fall) begin
                        state_q <= SHIFT;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    // EN rise wins over a coincident SCLK edge.
                    if (en_rise) begin
                        state_q <= CHECK;
                    end else if (sclk_rise && !en_s) begin
                        shift_q <= {shift_q[WORD_W-2:0], data_s};
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    if (cnt_q == CNT_W'(WORD_W)) begin
                        word_q                          <= shift_q;
                        shadow_q[shift_q[ADDR_W-1:0]]   <= shift_q[WORD_W-1:ADDR_W];
                        word_valid_q                    <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == SHIFT);
    assign rd_data    = shadow_q[rd_addr];

endmodule

// File: tb/tb_msi001_spi_slave.sv
// Testbench for msi001_spi_slave: table-driven frames with a scoreboard of
// expected word_valid/frame_err pulses, plus reset-mid-frame and latency sequences.
module tb_msi001_spi_slave;

    logic        clk;
    logic        reset;
    logic        spi_sclk_in;
    logic        spi_data_in;
    logic        spi_en_in;
    logic [23:0] word_out;
    logic        word_valid;
    logic        frame_err;
    logic        busy;
    logic [3:0]  rd_addr;
    logic [19:0] rd_data;

    msi001_spi_slave dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sclk_in (spi_sclk_in),
        .spi_data_in (spi_data_in),
        .spi_en_in   (spi_en_in),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [23:0] word;
    } exp_t;

    typedef struct {
        int          nbits;
        logic [63:0] bits;
        logic        exp_err;
        logic [23:0] exp_word;
        logic [3:0]  addr;
        logic [19:0] exp_rd;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests  = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest expected frame result.
    always @(negedge clk) begin
        if (!reset && (word_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected none",
                         word_valid, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind_err", {63'd0, frame_err}, {63'd0, mon_e.is_err});
                check("pulse_kind_valid", {63'd0, word_valid}, {63'd0, !mon_e.is_err});
                if (!mon_e.is_err) begin
                    check("word_at_valid", {40'd0, word_out}, {40'd0, mon_e.word});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_open();
        spi_en_in = 1'b0;
        wait_clks(8);
    endtask

    // One bit per SCLK period of 8 clk; data set while SCLK is low.
    task automatic send_bits(input int nbits, input logic [63:0] bits);
        for (int i = 0; i < nbits; i++) begin
            spi_data_in = bits[nbits-1-i];
            spi_sclk_in = 1'b0;
            wait_clks(4);
            spi_sclk_in = 1'b1;
            wait_clks(4);
        end
    endtask

    task automatic frame_close();
        spi_sclk_in = 1'b0;
        wait_clks(4);
        spi_en_in = 1'b1;
        wait_clks(24);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            wait_clks(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    vec_t vecs[9];
    int   lat;
    logic [19:0] rd_hist [13];

    initial begin
        vecs[0] = '{24, 64'h123451,       1'b0, 24'h123451, 4'h1, 20'h12345};
        vecs[1] = '{23, 64'h7FFFFF,       1'b1, 24'h123451, 4'h1, 20'h12345};
        vecs[2] = '{25, 64'h1FFFFFF,      1'b1, 24'h123451, 4'h1, 20'h12345};
        vecs[3] = '{40, 64'hFFFFFFFFFF,   1'b1, 24'h123451, 4'h1, 20'h12345};
        vecs[4] = '{24, 64'hABCDE2,       1'b0, 24'hABCDE2, 4'h2, 20'hABCDE};
        vecs[5] = '{24, 64'h000015,       1'b0, 24'h000015, 4'h5, 20'h00001};
        vecs[6] = '{24, 64'hFFFFF5,       1'b0, 24'hFFFFF5, 4'h5, 20'hFFFFF};
        vecs[7] = '{31, 64'h7FFFFFFF,     1'b1, 24'hFFFFF5, 4'h2, 20'hABCDE};
        vecs[8] = '{0,  64'h0,            1'b1, 24'hFFFFF5, 4'h1, 20'h12345};

        reset       = 1'b1;
        spi_sclk_in = 1'b0;
        spi_data_in = 1'b0;
        spi_en_in   = 1'b1;
        rd_addr     = 4'h0;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(10);

        check("rst_word_out", {40'd0, word_out}, 64'd0);
        check("rst_word_valid", {63'd0, word_valid}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        #1 check("rst_rd0", {44'd0, rd_data}, 64'd0);
        rd_addr = 4'h5;
        #1 check("rst_rd5", {44'd0, rd_data}, 64'd0);

        for (int v = 0; v < 9; v++) begin
            exp_q.push_back('{vecs[v].exp_err, vecs[v].bits[23:0]});
            frame_open();
            send_bits(vecs[v].nbits, vecs[v].bits);
            frame_close();
            drain();
            check($sformatf("vec%0d_word_out", v), {40'd0, word_out}, {40'd0, vecs[v].exp_word});
            rd_addr = vecs[v].addr;
            #1 check($sformatf("vec%0d_rd_data", v), {44'd0, rd_data}, {44'd0, vecs[v].exp_rd});
        end

        // Reset at bit 12 with EN low: abort, then the tail of that frame must be ignored.
        frame_open();
        send_bits(12, 64'h5A5);
        check("busy_mid_frame", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        wait_clks(2);
        check("midrst_word_out", {40'd0, word_out}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        rd_addr = 4'h1;
        #1 check("midrst_shadow_cleared", {44'd0, rd_data}, 64'd0);
        wait_clks(1);
        reset = 1'b0;
        send_bits(12, 64'hA53);
        frame_close();
        wait_clks(16);
        check("midrst_word_held", {40'd0, word_out}, 64'd0);
        exp_q.push_back('{1'b0, 24'h13579B});
        frame_open();
        send_bits(24, 64'h13579B);
        frame_close();
        drain();
        check("after_rst_word", {40'd0, word_out}, 64'h13579B);
        rd_addr = 4'hB;
        #1 check("after_rst_rd", {44'd0, rd_data}, 64'h13579);

        // Pin-level latency and read-during-write ordering at address B.
        exp_q.push_back('{1'b0, 24'h2468AB});
        frame_open();
        send_bits(24, 64'h2468AB);
        spi_sclk_in = 1'b0;
        wait_clks(4);
        spi_en_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            rd_hist[i] = rd_data;
            if (word_valid && lat == 0) lat = i;
        end
        check("latency_cycles", 64'(lat), 64'd4);
        check("rd_old_in_check", {44'd0, rd_hist[3]}, 64'h13579);
        check("rd_new_after_write", {44'd0, rd_hist[4]}, 64'h2468A);
        wait_clks(16);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
